window_stream_ctrl: RTL and testbench
=====================================

Name: window_stream_ctrl

Overview:
- Parametrised sliding-window generator for the streaming image pipeline.
- Accepts a raster pixel stream and stores it in a ring of line buffers.
- Emits one KERNEL x KERNEL window per output beat, with ready/valid backpressure on both sides.
- Sits between the pixel source and convolution/filter kernels; pulses an interrupt after each completed output row.

Parameters:
- PIX_W, 8, bits per pixel.
- IMG_W, 512, pixels per line; must be >= KERNEL.
- KERNEL, 3, window edge size; odd, >= 3.
- NUM_LINES, 4, line buffers in the ring; must be >= KERNEL+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  PIX_W  input pixel.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept in_data.
- out_data  out  KERNEL*KERNEL*PIX_W  window; slice [(r*KERNEL+k)*PIX_W +: PIX_W] = stored line r (r=0 oldest), column c+k.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts window.
- row_intr  out  1  one-cycle pulse after last window of a row is accepted.

Behaviour:
- Counters and pointers, widths $clog2 of their range:
  - wr_col (0..IMG_W-1) and wr_line (0..NUM_LINES-1): write position.
  - rd_col (0..IMG_W-1) and rd_base (0..NUM_LINES-1): read position; rd_base is the oldest line.
  - lines_valid (0..NUM_LINES): count of complete, unreleased lines.
- Input side:
  - in_ready = (lines_valid != NUM_LINES).
  - Accept on in_valid && in_ready: write in_data to line wr_line at wr_col, then increment wr_col.
  - At wr_col == IMG_W-1: wr_col wraps to 0, wr_line advances mod NUM_LINES, and the line counts as complete.
- Read FSM:
  - States: IDLE, RUN.
  - IDLE -> RUN when lines_valid >= KERNEL.
  - In RUN, a window at rd_col is issued whenever the output register is empty or being accepted (!out_valid || out_ready). Issue increments rd_col.
- Row end:
  - When the window at rd_col == IMG_W-1 is accepted: rd_col wraps to 0, rd_base advances mod NUM_LINES, the oldest line is released (lines_valid decrements), and row_intr pulses the following cycle.
  - FSM then returns to IDLE. It re-enters RUN on the next cycle if lines_valid is still >= KERNEL.
- Columns c+k > IMG_W-1 replicate column IMG_W-1 (clamp border).
- Output register:
  - out_data and out_valid are registered, so a window appears 1 cycle after issue.
  - While out_valid && !out_ready, out_data is held stable.
  - Sustained throughput is 1 window/cycle when out_ready is high.
- Simultaneous line completion and line release in the same cycle: lines_valid is unchanged.
- Pixel write and window read of different lines in the same cycle are always legal. The line being written is never part of the active window, guaranteed by the NUM_LINES >= KERNEL+1 rule.
- Reset, including mid-frame:
  - All counters, pointers and lines_valid go to 0; FSM goes to IDLE.
  - out_valid=0, out_data=0, row_intr=0.
  - in_ready is 1 on the first cycle after reset.
  - Line buffer contents are not cleared.

Optional Feature:
- Macro: WINDOW_ZERO_BORDER_EN.
- Defined: window columns beyond IMG_W-1 output 0 instead of the replicated last pixel.
- Undefined: clamp/replicate behaviour as above.
- No other behaviour differs between the two builds.

Decomposition:
- Shared package win_pkg holds:
  - the FSM state encoding (IDLE, RUN);
  - helper constants such as COL_W = $clog2(IMG_W) and LINE_W = $clog2(NUM_LINES);
  - a function computing the window slice offset.
- One sub-module, line_store:
  - a single line buffer of IMG_W x PIX_W;
  - synchronous write, combinational read of KERNEL consecutive columns with border handling;
  - instantiated NUM_LINES times via generate.

Test Plan (all cases use IMG_W=8, KERNEL=3, NUM_LINES=4, PIX_W=8):
- Fill: stream 24 pixels of value 0..23 with out_ready=1 → first out_valid 1 cycle after the FSM enters RUN. First window has rows {0,1,2},{8,9,10},{16,17,18}. Window at c=7 has rows {7,7,7},{15,15,15},{23,23,23}. row_intr pulses once after 8 windows.
- Backpressure out: hold out_ready=0 for 5 cycles mid-row → out_data stable and no window skipped or duplicated; the 8 windows of the row still appear in c order.
- Backpressure in: stream 40 pixels with out_ready=0 → in_ready drops after 32 accepted pixels (lines_valid=4). It rises 1 cycle after the first row completes once out_ready is released.
- Continuous frame: 64 pixels, out_ready=1 → 6 rows × 8 = 48 windows and 6 row_intr pulses. Row 5 is built from lines 5, 6, 7 (ring wrap of rd_base and wr_line).
- Reset mid-row: assert rst after 3 windows → next cycle out_valid=0, in_ready=1, row_intr=0. A fresh 24-pixel fill reproduces the first scenario exactly.
- WINDOW_ZERO_BORDER_EN build: repeat the first scenario → window at c=7 has rows {7,0,0},{15,0,0},{23,0,0}.

Source files
------------

// File: rtl/win_pkg.sv
// Shared types and helpers for the sliding-window stream controller.
// Holds the read FSM encoding, counter-width helper and window slice offset.
package win_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rd_state_t;

    // Default geometry; instances override through parameters.
    localparam int PIX_W_DEF     = 8;
    localparam int IMG_W_DEF     = 512;
    localparam int KERNEL_DEF    = 3;
    localparam int NUM_LINES_DEF = 4;

    // Width of a counter spanning 0..range-1 (at least one bit).
    function automatic int cnt_w(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

    // Bit offset of window pixel (row r, column k) in the output bus.
    function automatic int win_off(input int r, input int k,
                                   input int kernel, input int pix_w);
        return (r * kernel + k) * pix_w;
    endfunction

endpackage

// File: rtl/window_stream_ctrl_line_store.sv
// line_store: one IMG_W x PIX_W line buffer, synchronous write,
// combinational read of KERNEL consecutive columns with border handling.
// Ports: clk, wr_en/wr_col/wr_data (write), rd_col/rd_win (read).
// WINDOW_ZERO_BORDER_EN: columns past the line end read 0, else clamp.
module line_store
    import win_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int KERNEL = KERNEL_DEF,
    localparam int COL_W = cnt_w(IMG_W)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [COL_W-1:0]         wr_col,
    input  logic [PIX_W-1:0]         wr_data,
    input  logic [COL_W-1:0]         rd_col,
    output logic [KERNEL*PIX_W-1:0]  rd_win
);

    logic [PIX_W-1:0] mem [IMG_W];
    logic [COL_W:0]   col;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_col] <= wr_data;
        end
    end

    // One extra bit on col so rd_col+k past the last column is visible.
    always_comb begin
        rd_win = '0;
        col    = '0;
        for (int k = 0; k < KERNEL; k++) begin
            col = {1'b0, rd_col} + (COL_W+1)'(k);
            if (col > (COL_W+1)'(IMG_W - 1)) begin
`ifdef WINDOW_ZERO_BORDER_EN
                rd_win[k*PIX_W +: PIX_W] = '0;
`else
                rd_win[k*PIX_W +: PIX_W] = mem[IMG_W-1];
`endif
            end else begin
                rd_win[k*PIX_W +: PIX_W] = mem[col[COL_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/window_stream_ctrl.sv
// Sliding-window generator: raster pixels into a ring of line buffers,
// one KERNEL x KERNEL window per beat out, ready/valid on both sides.
// Ports: clk, rst (sync, active-high), in_data/in_valid/in_ready,
// out_data/out_valid/out_ready, row_intr (pulse after each output row).
// WINDOW_ZERO_BORDER_EN selects zero instead of replicated right border.
module window_stream_ctrl
    import win_pkg::*;
#(
    parameter int PIX_W     = PIX_W_DEF,
    parameter int IMG_W     = IMG_W_DEF,
    parameter int KERNEL    = KERNEL_DEF,
    parameter int NUM_LINES = NUM_LINES_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PIX_W-1:0]                in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [KERNEL*KERNEL*PIX_W-1:0]  out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            row_intr
);

    localparam int COL_W  = cnt_w(IMG_W);
    localparam int LINE_W = cnt_w(NUM_LINES);
    localparam int LV_W   = cnt_w(NUM_LINES + 1);
    localparam int ROW_W  = KERNEL * PIX_W;
    localparam int WIN_W  = KERNEL * ROW_W;

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);

    rd_state_t         state;
    logic [COL_W-1:0]  wr_col;
    logic [COL_W-1:0]  rd_col;
    logic [LINE_W-1:0] wr_line;
    logic [LINE_W-1:0] rd_base;
    logic [LV_W-1:0]   lines_valid;
    logic              out_last;
    logic              last_issued;

    logic              wr_fire;
    logic              line_done;
    logic              issue;
    logic              release_row;

    logic [ROW_W-1:0]  line_win [NUM_LINES];
    logic [ROW_W-1:0]  row_data [KERNEL];
    logic [LINE_W:0]   sel;
    logic [WIN_W-1:0]  win_next;

    assign in_ready    = (lines_valid != LV_W'(NUM_LINES));
    assign wr_fire     = in_valid && in_ready;
    assign line_done   = wr_fire && (wr_col == LAST_COL);
    // Once the row's last window is issued, hold off until it is taken.
    assign issue       = (state == RUN) && !last_issued
                         && (!out_valid || out_ready);
    assign release_row = out_valid && out_ready && out_last;

    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
        line_store #(
            .PIX_W  (PIX_W),
            .IMG_W  (IMG_W),
            .KERNEL (KERNEL)
        ) u_line (
            .clk     (clk),
            .wr_en   (wr_fire && (wr_line == LINE_W'(l))),
            .wr_col  (wr_col),
            .wr_data (in_data),
            .rd_col  (rd_col),
            .rd_win  (line_win[l])
        );
    end

    // Window row r comes from ring slot (rd_base + r) mod NUM_LINES.
    always_comb begin
        sel      = '0;
        row_data = '{default: '0};
        for (int r = 0; r < KERNEL; r++) begin
            sel = {1'b0, rd_base} + (LINE_W+1)'(r);
            if (sel >= (LINE_W+1)'(NUM_LINES)) begin
                sel = sel - (LINE_W+1)'(NUM_LINES);
            end
            row_data[r] = line_win[sel[LINE_W-1:0]];
        end
    end

    always_comb begin
        win_next = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int k = 0; k < KERNEL; k++) begin
                win_next[win_off(r, k, KERNEL, PIX_W) +: PIX_W] =
                    row_data[r][k*PIX_W +: PIX_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_col      <= '0;
            wr_line     <= '0;
            rd_col      <= '0;
            rd_base     <= '0;
            lines_valid <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            last_issued <= 1'b0;
            row_intr    <= 1'b0;
        end else begin
            row_intr <= 1'b0;

            if (wr_fire) begin
                if (wr_col == LAST_COL) begin
                    wr_col  <= '0;
                    wr_line <= (wr_line == LAST_LINE) ? '0
                               : wr_line + LINE_W'(1);
                end else begin
                    wr_col <= wr_col + COL_W'(1);
                end
            end

            lines_valid <= lines_valid + LV_W'(line_done)
                           - LV_W'(release_row);

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (lines_valid >= LV_W'(KERNEL)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        out_data  <= win_next;
                        out_valid <= 1'b1;
                        out_last  <= (rd_col == LAST_COL);
                        if (rd_col == LAST_COL) begin
                            last_issued <= 1'b1;
                        end else begin
                            rd_col <= rd_col + COL_W'(1);
                        end
                    end
                    if (release_row) begin
                        rd_col      <= '0;
                        rd_base     <= (rd_base == LAST_LINE) ? '0
                                       : rd_base + LINE_W'(1);
                        last_issued <= 1'b0;
                        row_intr    <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_stream_ctrl.sv
// Self-checking bench for window_stream_ctrl (IMG_W=8, KERNEL=3).
// Scoreboard of expected windows plus a table of hand-computed windows.
module tb_window_stream_ctrl;

    localparam int PIX_W     = 8;
    localparam int IMG_W     = 8;
    localparam int KERNEL    = 3;
    localparam int NUM_LINES = 4;
    localparam int WIN_W     = KERNEL * KERNEL * PIX_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [PIX_W-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIN_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             row_intr;

    window_stream_ctrl #(
        .PIX_W     (PIX_W),
        .IMG_W     (IMG_W),
        .KERNEL    (KERNEL),
        .NUM_LINES (NUM_LINES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .row_intr  (row_intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIN_W-1:0] d;
        int               c;
    } exp_t;

    typedef struct {
        int               scen;
        int               idx;
        logic [WIN_W-1:0] win;
    } vec_t;

    exp_t             exp_q [$];
    exp_t             e;
    vec_t             vecs [8];
    logic [WIN_W-1:0] got [64];
    logic [PIX_W-1:0] pix_mem [64];
    int n_got, n_intr, n_acc, n_lines, col_in, n_hold;
    int cyc = 0;
    int first_valid_cyc, last_pix_cyc, first_row_cyc;
    int checks = 0;
    int errors = 0;
    logic             intr_exp = 1'b0;
    logic             hold_v = 1'b0;
    logic [WIN_W-1:0] hold_d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WIN_W-1:0] act,
                       input logic [WIN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIN_W-1:0] win9(
        input int a0, input int a1, input int a2,
        input int a3, input int a4, input int a5,
        input int a6, input int a7, input int a8);
        int a [9];
        logic [WIN_W-1:0] w;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        w = '0;
        for (int i = 0; i < 9; i++) w[i*PIX_W +: PIX_W] = PIX_W'(a[i]);
        return w;
    endfunction

    task automatic push_row(input int b);
        logic [WIN_W-1:0] d;
        logic [PIX_W-1:0] p;
        int col;
        for (int c = 0; c < IMG_W; c++) begin
            d = '0;
            for (int r = 0; r < KERNEL; r++) begin
                for (int k = 0; k < KERNEL; k++) begin
                    col = c + k;
`ifdef WINDOW_ZERO_BORDER_EN
                    p = (col > IMG_W - 1) ? '0
                        : pix_mem[(b + r) * IMG_W + col];
`else
                    if (col > IMG_W - 1) col = IMG_W - 1;
                    p = pix_mem[(b + r) * IMG_W + col];
`endif
                    d[(r*KERNEL+k)*PIX_W +: PIX_W] = p;
                end
            end
            exp_q.push_back('{d, c});
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        n_got = 0; n_intr = 0; n_acc = 0; n_lines = 0;
        col_in = 0; n_hold = 0;
        first_valid_cyc = -1; last_pix_cyc = -1; first_row_cyc = -1;
    endtask

    task automatic send(input int n, input int base, input int budget);
        int sent = 0;
        int spent = 0;
        while (sent < n && spent < budget) begin
            in_valid = 1'b1;
            in_data  = PIX_W'(base + sent);
            @(negedge clk);
            if (in_ready) begin
                pix_mem[n_lines * IMG_W + col_in] = in_data;
                n_acc++;
                sent++;
                last_pix_cyc = cyc + 1;
                if (col_in == IMG_W - 1) begin
                    col_in = 0;
                    n_lines++;
                    if (n_lines >= KERNEL) push_row(n_lines - KERNEL);
                end else begin
                    col_in++;
                end
            end
            @(posedge clk); #1;
            spent++;
        end
        in_valid = 1'b0;
        chk("send_done", WIN_W'(sent), WIN_W'(n));
    endtask

    task automatic wait_got(input int n, input int budget);
        int spent = 0;
        while (n_got < n && spent < budget) begin
            @(posedge clk); #2;
            spent++;
        end
        chk("wait_windows", WIN_W'(n_got), WIN_W'(n));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_sb();
        rst = 1'b0;
    endtask

    task automatic apply_table(input int scen);
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].scen == scen) begin
                chk($sformatf("table_s%0d_w%0d", scen, vecs[i].idx),
                    got[vecs[i].idx], vecs[i].win);
            end
        end
    endtask

    task automatic finish_row_checks(input int rows);
        repeat (3) @(posedge clk);
        #2;
        chk("row_intr_count", WIN_W'(n_intr), WIN_W'(rows));
        chk("queue_drained", WIN_W'(exp_q.size()), WIN_W'(0));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            intr_exp = 1'b0;
            hold_v   = 1'b0;
        end else begin
            if (row_intr || intr_exp) begin
                chk("row_intr", WIN_W'(row_intr), WIN_W'(intr_exp));
            end
            if (row_intr) n_intr++;
            intr_exp = 1'b0;
            if (hold_v) begin
                n_hold++;
                chk("hold_valid", WIN_W'(out_valid), WIN_W'(1));
                chk("hold_data", out_data, hold_d);
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_window: got %h expected none",
                             out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("window_c%0d", e.c), out_data, e.d);
                    if (n_got < 64) got[n_got] = out_data;
                    n_got++;
                    if (e.c == IMG_W - 1) begin
                        intr_exp = 1'b1;
                        if (first_row_cyc < 0) first_row_cyc = cyc + 1;
                    end
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
        end
    end

    initial begin
        int spent;
        vecs[0] = '{1, 0, win9(0, 1, 2, 8, 9, 10, 16, 17, 18)};
        vecs[1] = '{1, 3, win9(3, 4, 5, 11, 12, 13, 19, 20, 21)};
        vecs[4] = '{4, 0, win9(100, 101, 102, 108, 109, 110,
                               116, 117, 118)};
        vecs[5] = '{5, 40, win9(40, 41, 42, 48, 49, 50, 56, 57, 58)};
`ifdef WINDOW_ZERO_BORDER_EN
        vecs[2] = '{1, 6, win9(6, 7, 0, 14, 15, 0, 22, 23, 0)};
        vecs[3] = '{1, 7, win9(7, 0, 0, 15, 0, 0, 23, 0, 0)};
        vecs[6] = '{5, 47, win9(47, 0, 0, 55, 0, 0, 63, 0, 0)};
`else
        vecs[2] = '{1, 6, win9(6, 7, 7, 14, 15, 15, 22, 23, 23)};
        vecs[3] = '{1, 7, win9(7, 7, 7, 15, 15, 15, 23, 23, 23)};
        vecs[6] = '{5, 47, win9(47, 47, 47, 55, 55, 55,
                                63, 63, 63)};
`endif
        vecs[7] = '{4, 7, win9(107, 107, 107, 115, 115, 115,
                               123, 123, 123)};
`ifdef WINDOW_ZERO_BORDER_EN
        vecs[7] = '{4, 7, win9(107, 0, 0, 115, 0, 0, 123, 0, 0)};
`endif

        // Reset state
        do_reset();
        chk("rst_out_valid", WIN_W'(out_valid), WIN_W'(0));
        chk("rst_in_ready", WIN_W'(in_ready), WIN_W'(1));
        chk("rst_row_intr", WIN_W'(row_intr), WIN_W'(0));
        chk("rst_out_data", out_data, WIN_W'(0));

        // Fill
        out_ready = 1'b1;
        send(24, 0, 200);
        wait_got(8, 100);
        finish_row_checks(1);
        chk("first_valid_latency", WIN_W'(first_valid_cyc),
            WIN_W'(last_pix_cyc + 2));
        apply_table(1);

        // Output backpressure mid-row
        do_reset();
        out_ready = 1'b1;
        fork
            send(24, 0, 200);
            begin
                wait_got(3, 200);
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_got(8, 100);
        finish_row_checks(1);
        chk("hold_cycles_seen", WIN_W'(n_hold >= 4), WIN_W'(1));
        apply_table(1);

        // Input backpressure
        do_reset();
        out_ready = 1'b0;
        fork
            send(40, 100, 400);
            begin
                spent = 0;
                while (n_acc < 32 && spent < 400) begin
                    @(posedge clk); #2;
                    spent++;
                end
                repeat (4) @(posedge clk);
                #2;
                chk("in_ready_full", WIN_W'(in_ready), WIN_W'(0));
                chk("accepted_at_full", WIN_W'(n_acc), WIN_W'(32));
                out_ready = 1'b1;
                spent = 0;
                while (!in_ready && spent < 100) begin
                    @(posedge clk); #2;
                    spent++;
                end
                chk("in_ready_rise_cycle", WIN_W'(cyc),
                    WIN_W'(first_row_cyc));
            end
        join
        wait_got(24, 300);
        finish_row_checks(3);
        apply_table(4);

        // Continuous frame with ring wrap
        do_reset();
        out_ready = 1'b1;
        send(64, 0, 600);
        wait_got(48, 600);
        finish_row_checks(6);
        apply_table(5);

        // Reset mid-row, then a fresh fill
        do_reset();
        out_ready = 1'b1;
        send(24, 0, 200);
        wait_got(3, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", WIN_W'(out_valid), WIN_W'(0));
        chk("midrst_in_ready", WIN_W'(in_ready), WIN_W'(1));
        chk("midrst_row_intr", WIN_W'(row_intr), WIN_W'(0));
        clear_sb();
        rst = 1'b0;
        send(24, 0, 200);
        wait_got(8, 100);
        finish_row_checks(1);
        chk("refill_latency", WIN_W'(first_valid_cyc),
            WIN_W'(last_pix_cyc + 2));
        apply_table(1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
